// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fir_pkg
// Purpose  : Shared types and default sizes for the single-MAC FIR sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package fir_pkg;

  localparam int NTAPS_DEF = 16;  // number of filter taps (power of 2, >= 2)
  localparam int AW_DEF    = 4;   // log2(NTAPS_DEF)
  localparam int DW_DEF    = 8;   // input sample width
  localparam int OUT_W     = 18;  // filter output width produced by the MAC

  typedef enum logic [2:0] {
    CLEAR = 3'd0,
    IDLE  = 3'd1,
    WRITE = 3'd2,
    MAC   = 3'd3,
    DRAIN = 3'd4,
    OUT   = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/fir_mac_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : fir_mac_sequencer_if
// Purpose  : Sample handshake, RAM/ROM addressing and MAC strobe bundle.
//            master = sequencer side, slave = source/datapath/consumer side.
// Revision : 1.0 - initial release
// ============================================================================
interface fir_mac_sequencer_if
  import fir_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          clr_req;
  logic          smp_we;
  logic [AW-1:0] smp_waddr;
  logic [DW-1:0] smp_wdata;
  logic [AW-1:0] smp_raddr;
  logic [AW-1:0] coef_addr;
  logic          acc_en;
  logic          acc_first;
  logic          out_valid;
  logic          out_ready;
  logic          busy;

  modport master (
    input  in_valid, in_data, clr_req, out_ready,
    output in_ready, smp_we, smp_waddr, smp_wdata, smp_raddr, coef_addr,
           acc_en, acc_first, out_valid, busy
  );

  modport slave (
    output in_valid, in_data, clr_req, out_ready,
    input  in_ready, smp_we, smp_waddr, smp_wdata, smp_raddr, coef_addr,
           acc_en, acc_first, out_valid, busy
  );

endinterface
`default_nettype wire

// File: rtl/fir_tap_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : fir_tap_addr_gen
// Purpose  : Modulo-NTAPS tap counter and circular read address (wptr - k).
// Revision : 1.0 - initial release
// ============================================================================
module fir_tap_addr_gen
  import fir_pkg::*;
#(
  parameter int NTAPS = NTAPS_DEF,
  parameter int AW    = AW_DEF
) (
  input  wire logic          clk,
  input  wire logic          rst,    // asynchronous, active low
  input  wire logic          en,     // one MAC cycle
  input  wire logic [AW-1:0] wptr,
  output logic      [AW-1:0] k,
  output logic      [AW-1:0] raddr,
  output logic               last
);

  logic [AW-1:0] k_q, k_d;

  // Advance the tap index once per MAC cycle; NTAPS is a power of 2 so it wraps for free.
  always_comb begin
    k_d = k_q;
    if (en) k_d = k_q + 1'b1;
  end

  // Tap index register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) k_q <= '0;
    else      k_q <= k_d;
  end

  assign k     = k_q;
  assign raddr = wptr - k_q;                         // newest sample first, modulo 2^AW
  assign last  = en && (k_q == AW'(NTAPS - 1));

endmodule
`default_nettype wire

// File: rtl/fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fir_mac_sequencer
// Purpose  : Controller for a time-multiplexed single-MAC FIR: stores samples
//            in a circular RAM and sequences NTAPS coefficient/sample reads.
// Revision : 1.0 - initial release
// ============================================================================
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int NTAPS  = NTAPS_DEF,
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = 1            // RAM/ROM read latency, 0..2
) (
  input  wire logic           clk,
  input  wire logic           rst,    // asynchronous, active low
  fir_mac_sequencer_if.master bus
);

  state_e        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic [DW-1:0] sample_q, sample_d;
  logic [1:0]    drain_q, drain_d;

  logic          mac_en;
  logic          tap_first;
  logic          tap_last;
  logic [AW-1:0] tap_k;
  logic [AW-1:0] tap_raddr;

  fir_tap_addr_gen #(
    .NTAPS (NTAPS),
    .AW    (AW)
  ) u_tap_addr_gen (
    .clk   (clk),
    .rst   (rst),
    .en    (mac_en),
    .wptr  (wptr_q),
    .k     (tap_k),
    .raddr (tap_raddr),
    .last  (tap_last)
  );

  assign tap_first = mac_en && (tap_k == '0);

  // Next-state and per-state datapath controls.
  always_comb begin
    state_d       = state_q;
    wptr_d        = wptr_q;
    clr_cnt_d     = clr_cnt_q;
    sample_d      = sample_q;
    drain_d       = drain_q;
    mac_en        = 1'b0;
    bus.in_ready  = 1'b0;
    bus.smp_we    = 1'b0;
    bus.smp_waddr = '0;
    bus.smp_wdata = '0;
    bus.smp_raddr = '0;
    bus.coef_addr = '0;
    bus.out_valid = 1'b0;

    case (state_q)
      CLEAR: begin
        // Gated by rst so the RAM is not written while reset is held.
        bus.smp_we    = rst;
        bus.smp_waddr = clr_cnt_q;
        clr_cnt_d     = clr_cnt_q + 1'b1;
        wptr_d        = '0;
        if (clr_cnt_q == AW'(NTAPS - 1)) begin
          clr_cnt_d = '0;
          state_d   = IDLE;
        end
      end
      IDLE: begin
        // A history clear wins over a sample offered in the same cycle.
        bus.in_ready = !bus.clr_req;
        if (bus.clr_req) begin
          clr_cnt_d = '0;
          state_d   = CLEAR;
        end else if (bus.in_valid) begin
          sample_d = bus.in_data;
          state_d  = WRITE;
        end
      end
      WRITE: begin
        bus.smp_we    = 1'b1;
        bus.smp_waddr = wptr_q;
        bus.smp_wdata = sample_q;
        state_d       = MAC;
      end
      MAC: begin
        mac_en        = 1'b1;
        bus.smp_raddr = tap_raddr;
        bus.coef_addr = tap_k;
        if (tap_last) begin
          wptr_d  = wptr_q + 1'b1;
          drain_d = 2'(RD_LAT - 1);
          state_d = (RD_LAT == 0) ? OUT : DRAIN;
        end
      end
      DRAIN: begin
        if (drain_q == 2'd0) state_d = OUT;
        else                 drain_d = drain_q - 2'd1;
      end
      OUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = CLEAR;
    endcase
  end

  assign bus.busy = (state_q != IDLE);

  // Control state registers; reset restarts with a full history clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= CLEAR;
      wptr_q    <= '0;
      clr_cnt_q <= '0;
      sample_q  <= '0;
      drain_q   <= '0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      clr_cnt_q <= clr_cnt_d;
      sample_q  <= sample_d;
      drain_q   <= drain_d;
    end
  end

  // Accumulate strobes line up with read data RD_LAT cycles after the address.
  generate
    if (RD_LAT == 0) begin : g_lat0
      assign bus.acc_en    = mac_en;
      assign bus.acc_first = tap_first;
    end else begin : g_latn
      logic [RD_LAT-1:0] en_q, en_d;
      logic [RD_LAT-1:0] first_q, first_d;

      // Shift the MAC-cycle and first-tap flags down the latency pipe.
      always_comb begin
        en_d       = en_q;
        first_d    = first_q;
        en_d[0]    = mac_en;
        first_d[0] = tap_first;
        for (int i = 1; i < RD_LAT; i++) begin
          en_d[i]    = en_q[i-1];
          first_d[i] = first_q[i-1];
        end
      end

      // Strobe pipeline registers, flushed by reset.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          en_q    <= '0;
          first_q <= '0;
        end else begin
          en_q    <= en_d;
          first_q <= first_d;
        end
      end

      assign bus.acc_en    = en_q[RD_LAT-1];
      assign bus.acc_first = first_q[RD_LAT-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_mac_sequencer
// Purpose  : Directed self-checking bench for fir_mac_sequencer (defaults).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_mac_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  fir_mac_sequencer_if #(.AW(4), .DW(8)) bus ();

  fir_mac_sequencer #(
    .NTAPS  (16),
    .AW     (4),
    .DW     (8),
    .RD_LAT (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; sample point sits 2 time units after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Expects to be called in the first CLEAR cycle; ends in IDLE.
  task automatic clear_sweep();
    for (int i = 0; i < 16; i++) begin
      check_eq("clr_we",        bus.smp_we,    1);
      check_eq("clr_waddr",     bus.smp_waddr, i);
      check_eq("clr_wdata",     bus.smp_wdata, 0);
      check_eq("clr_in_ready",  bus.in_ready,  0);
      check_eq("clr_out_valid", bus.out_valid, 0);
      check_eq("clr_acc_en",    bus.acc_en,    0);
      check_eq("clr_busy",      bus.busy,      1);
      cyc();
    end
    check_eq("clr_done_in_ready", bus.in_ready, 1);
    check_eq("clr_done_busy",     bus.busy,     0);
    check_eq("clr_done_we",       bus.smp_we,   0);
  endtask

  // Full transaction from IDLE: accept d, expect write to wp, run 16 taps,
  // then hold the result for 'hold' cycles with in_valid/clr_req pushed in.
  task automatic do_sample(input logic [7:0] d, input logic [3:0] wp, input int hold);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    #1;
    check_eq("idle_in_ready", bus.in_ready, 1);
    check_eq("idle_busy",     bus.busy,     0);
    cyc();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #1;
    check_eq("wr_we",    bus.smp_we,    1);
    check_eq("wr_waddr", bus.smp_waddr, wp);
    check_eq("wr_wdata", bus.smp_wdata, d);
    check_eq("wr_busy",  bus.busy,      1);
    for (int k = 0; k < 16; k++) begin
      cyc();
      check_eq("mac_raddr",     bus.smp_raddr, 4'(wp - k));
      check_eq("mac_coef",      bus.coef_addr, k);
      check_eq("mac_we",        bus.smp_we,    0);
      check_eq("mac_acc_en",    bus.acc_en,    (k >= 1));
      check_eq("mac_acc_first", bus.acc_first, (k == 1));
      check_eq("mac_out_valid", bus.out_valid, 0);
    end
    cyc();
    check_eq("drn_acc_en",    bus.acc_en,    1);
    check_eq("drn_acc_first", bus.acc_first, 0);
    check_eq("drn_out_valid", bus.out_valid, 0);
    cyc();
    check_eq("out_valid",    bus.out_valid, 1);
    check_eq("out_in_ready", bus.in_ready,  0);
    check_eq("out_acc_en",   bus.acc_en,    0);
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      bus.clr_req  = 1'b1;
      #1;
      check_eq("hold_out_valid", bus.out_valid, 1);
      check_eq("hold_in_ready",  bus.in_ready,  0);
      check_eq("hold_we",        bus.smp_we,    0);
      cyc();
    end
    bus.in_valid  = 1'b0;
    bus.clr_req   = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check_eq("acc_out_valid", bus.out_valid, 1);
    cyc();
    bus.out_ready = 1'b0;
    #1;
    check_eq("post_out_valid", bus.out_valid, 0);
    check_eq("post_busy",      bus.busy,      0);
  endtask

  // Everything except busy must be low while in reset.
  task automatic check_reset_outputs(input string tag);
    check_eq(tag, {bus.smp_we, bus.smp_waddr, bus.smp_wdata, bus.smp_raddr,
                   bus.coef_addr, bus.acc_en, bus.acc_first, bus.out_valid,
                   bus.in_ready}, 0);
    check_eq("rst_busy", bus.busy, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.clr_req   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state and the power-on clear sweep.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst_outputs");
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    clear_sweep();

    // First sample: write to address 0, reads 0,15,...,1.
    do_sample(8'hFA, 4'd0, 0);

    // clr_req beats a simultaneous sample; wptr restarts at 0.
    bus.clr_req  = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    #1;
    check_eq("clrreq_in_ready", bus.in_ready, 0);
    cyc();
    bus.clr_req  = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check_eq("clrreq_we", bus.smp_we, 1);
    clear_sweep();

    // 17 back-to-back samples: addresses 0..15 then wrap to 0.
    for (int i = 0; i < 17; i++) begin
      do_sample(8'(8'h10 + i), 4'(i), 0);
    end

    // Result held 10 cycles with in_valid and clr_req ignored.
    do_sample(8'hA5, 4'd1, 10);

    // Reset in the middle of MAC tap 7.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    #1;
    check_eq("abort_in_ready", bus.in_ready, 1);
    cyc();
    bus.in_valid = 1'b0;
    #1;
    check_eq("abort_wr_waddr", bus.smp_waddr, 2);
    for (int k = 0; k < 8; k++) cyc();
    check_eq("abort_raddr", bus.smp_raddr, 4'd11);
    check_eq("abort_coef",  bus.coef_addr, 7);
    rst = 1'b0;
    #1;
    check_reset_outputs("abort_rst_outputs");
    @(posedge clk);
    #1;
    check_reset_outputs("abort_rst_hold");
    rst = 1'b1;
    #1;
    clear_sweep();
    for (int i = 0; i < 5; i++) begin
      check_eq("abort_no_out_valid", bus.out_valid, 0);
      check_eq("abort_idle_busy",    bus.busy,      0);
      cyc();
    end
    do_sample(8'h3C, 4'd0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
- Controller for a time-multiplexed, single-MAC version of the 8-bit-in / 18-bit-out FIR filter.
- Accepts one sample per handshake and writes it into a circular sample RAM.
- Sequences NTAPS coefficient/sample read pairs into an external MAC and raises out_valid when the accumulated result is ready.
- Sits between the sample source (48 kHz stream) and the shared MAC/RAM/ROM datapath; it holds no arithmetic itself.

Parameters:
- NTAPS, 16, number of filter taps; must be a power of 2 and at least 2.
- AW, 4, address width, equal to log2(NTAPS).
- DW, 8, input sample width.
- RD_LAT, 1, read latency of the sample RAM and coefficient ROM, in cycles (0..2).

Ports:
- clk, in, 1, system clock; all state updates on the rising edge.
- rst, in, 1, asynchronous active-low reset.
- in_valid, in, 1, sample offered.
- in_ready, out, 1, controller can accept a sample.
- in_data, in, DW, sample value.
- clr_req, in, 1, request to zero the sample history.
- smp_we, out, 1, sample RAM write enable.
- smp_waddr, out, AW, sample RAM write address.
- smp_wdata, out, DW, sample RAM write data.
- smp_raddr, out, AW, sample RAM read address.
- coef_addr, out, AW, coefficient ROM address.
- acc_en, out, 1, MAC accumulate strobe, aligned to read data.
- acc_first, out, 1, with acc_en: load the product instead of adding it.
- out_valid, out, 1, MAC result valid; held until accepted.
- out_ready, in, 1, consumer accepts the result.
- busy, out, 1, high in any state other than IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to CLEAR; wptr=0; clear counter=0.
  - All outputs are 0 except busy=1.
  - Release of reset is synchronous to clk.
- CLEAR:
  - Runs for NTAPS cycles with smp_we=1, smp_wdata=0, smp_waddr=clear counter (0..NTAPS-1).
  - Then goes to IDLE with wptr=0.
  - in_ready=0 throughout.
- IDLE:
  - in_ready=1 only when out_valid=0.
  - If clr_req=1, go to CLEAR. clr_req takes priority over a simultaneous in_valid, and that sample is not accepted (in_ready drops in the same cycle).
  - Otherwise, on in_valid && in_ready, latch in_data and go to WRITE.
- WRITE (1 cycle):
  - smp_we=1, smp_waddr=wptr, smp_wdata=latched sample.
  - Go to MAC with tap counter k=0.
- MAC (NTAPS cycles):
  - Each cycle: smp_raddr=(wptr-k) mod 2^AW, coef_addr=k, then k increments.
  - After the last tap (k=NTAPS-1), wptr increments (wraps NTAPS-1 -> 0) and the state goes to DRAIN.
- Accumulate strobes:
  - acc_en is the MAC-cycle indicator delayed by RD_LAT cycles.
  - acc_first is asserted only on the strobe for k=0.
- DRAIN:
  - Lasts RD_LAT cycles; then out_valid is set and the state goes to OUT.
- OUT:
  - out_valid stays high until out_ready=1.
  - On out_valid && out_ready, out_valid clears the next cycle and the state goes to IDLE.
- Latency: a sample accepted at edge t gives out_valid=1 at cycle t+2+NTAPS+RD_LAT (t+19 with defaults).
- Maximum throughput: one sample per NTAPS+RD_LAT+3 cycles.
- smp_we is never high outside CLEAR and WRITE.
- acc_en is never high outside the MAC/DRAIN window.
- clr_req outside IDLE is ignored and not remembered.
- A reset during MAC or OUT aborts the operation: no out_valid pulse, a full CLEAR sweep follows, and wptr is reset.

Decomposition:
- Package fir_pkg:
  - state enum {CLEAR, IDLE, WRITE, MAC, DRAIN, OUT};
  - NTAPS, AW and DW defaults;
  - the filter output width constant (18).
- Sub-module fir_tap_addr_gen: modulo-NTAPS tap counter and the (wptr-k) read-address subtractor, with a last-tap flag.
- The acc_en/acc_first delay line stays in the top level.

Test Plan:
- Reset released -> 16 cycles of smp_we=1 with smp_waddr 0..15 and smp_wdata=0, then in_ready=1 and busy=0.
- Sample 8'hFA accepted at cycle t -> smp_we at t+1 to address 0; smp_raddr sequence 0,15,14,...,1 with coef_addr 0..15; acc_first together with the first acc_en at t+3; out_valid at t+19.
- 17 back-to-back samples with out_ready=1 -> write addresses 0..15 then 0 (wrap-around); 17th MAC read sequence is 0,15,...,1.
- out_ready=0 for 10 cycles after out_valid -> out_valid held, in_ready=0 and in_valid ignored; accepted on the first cycle out_ready=1.
- clr_req and in_valid both asserted in IDLE -> sample not accepted, CLEAR sweep runs, wptr=0 afterwards.
- rst asserted at MAC tap 7 -> all outputs 0 immediately; after release a full CLEAR sweep runs and no out_valid pulse occurs.
